// File: rtl/midi_defs.sv
// Shared MIDI 1.0 constants, parser state encodings and the message-length helper.
package midi_defs;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CTRL     = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHAN_AT  = 4'hD;
    localparam logic [3:0] BEND     = 4'hE;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_D1    = 2'd1;
    localparam logic [1:0] ST_D2    = 2'd2;
    localparam logic [1:0] ST_SYSEX = 2'd3;

    // Number of data bytes that follow a channel status nibble.
    function automatic logic [1:0] midi_data_len(input logic [3:0] nibble);
        return (nibble == PROG || nibble == CHAN_AT) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI 1.0 channel-voice parser: running status, real-time skip, SysEx discard,
// registered single-cycle event pulses and held field outputs.
module midi_parser #(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        note_on,
    output logic        note_off,
    output logic        cc_valid,
    output logic        prog_valid,
    output logic        bend_valid,
    output logic [3:0]  channel,
    output logic [6:0]  key,
    output logic [6:0]  value,
    output logic [13:0] bend,
    output logic        sync_err
);
    import midi_defs::*;

    logic [1:0]  state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [6:0]  d1_q, d1_d;

    logic        note_on_d, note_off_d, cc_valid_d, prog_valid_d, bend_valid_d, sync_err_d;
    logic [3:0]  channel_d;
    logic [6:0]  key_d, value_d;
    logic [13:0] bend_d;

    logic        complete;
    logic [6:0]  msg_d1;
    logic [6:0]  msg_d2;
    logic        accept;

    assign accept = OMNI || (status_q[3:0] == CHANNEL);

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        d1_d         = d1_q;
        note_on_d    = 1'b0;
        note_off_d   = 1'b0;
        cc_valid_d   = 1'b0;
        prog_valid_d = 1'b0;
        bend_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        channel_d    = channel;
        key_d        = key;
        value_d      = value;
        bend_d       = bend;
        complete     = 1'b0;
        msg_d1       = d1_q;
        msg_d2       = byte_data[6:0];

        // Real-time bytes fall through untouched.
        if (byte_valid && byte_data < RT_MIN) begin
            if (byte_data[7]) begin
                if (byte_data >= SYSEX_START) begin
                    status_d = 8'h00;
                    state_d  = (byte_data == SYSEX_START) ? ST_SYSEX : ST_IDLE;
                end else begin
                    status_d = byte_data;
                    state_d  = ST_D1;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: sync_err_d = 1'b1;
                    ST_D1: begin
                        d1_d = byte_data[6:0];
                        if (midi_data_len(status_q[7:4]) == 2'd1) begin
                            complete = 1'b1;
                            msg_d1   = byte_data[6:0];
                        end else begin
                            state_d = ST_D2;
                        end
                    end
                    ST_D2: begin
                        complete = 1'b1;
                        state_d  = ST_D1;
                    end
                    ST_SYSEX: begin
                    end
                endcase
            end
        end

        if (complete && accept) begin
            case (status_q[7:4])
                NOTE_OFF: begin
                    note_off_d = 1'b1;
                    channel_d  = status_q[3:0];
                    key_d      = msg_d1;
                    value_d    = msg_d2;
                end
                NOTE_ON: begin
                    // Velocity 0 is a note-off by MIDI convention.
                    note_on_d  = (msg_d2 != 7'd0);
                    note_off_d = (msg_d2 == 7'd0);
                    channel_d  = status_q[3:0];
                    key_d      = msg_d1;
                    value_d    = msg_d2;
                end
                CTRL: begin
                    cc_valid_d = 1'b1;
                    channel_d  = status_q[3:0];
                    key_d      = msg_d1;
                    value_d    = msg_d2;
                end
                PROG: begin
                    prog_valid_d = 1'b1;
                    channel_d    = status_q[3:0];
                    value_d      = msg_d1;
                end
                BEND: begin
                    bend_valid_d = 1'b1;
                    channel_d    = status_q[3:0];
                    bend_d       = {msg_d2, msg_d1};
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            status_q   <= 8'h00;
            d1_q       <= 7'd0;
            note_on    <= 1'b0;
            note_off   <= 1'b0;
            cc_valid   <= 1'b0;
            prog_valid <= 1'b0;
            bend_valid <= 1'b0;
            sync_err   <= 1'b0;
            channel    <= 4'd0;
            key        <= 7'd0;
            value      <= 7'd0;
            bend       <= 14'h2000;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            d1_q       <= d1_d;
            note_on    <= note_on_d;
            note_off   <= note_off_d;
            cc_valid   <= cc_valid_d;
            prog_valid <= prog_valid_d;
            bend_valid <= bend_valid_d;
            sync_err   <= sync_err_d;
            channel    <= channel_d;
            key        <= key_d;
            value      <= value_d;
            bend       <= bend_d;
        end
    end

endmodule
